// File: rtl/status_register.sv
`default_nettype none
// ============================================================================
//  Module   : status_register
//  Purpose  : 6502-style processor status register (P). Holds the six stored
//             flags N,V,D,I,Z,C; bits 5 and 4 exist only in the pushed byte.
//             Accepts ALU flag updates, explicit flag instructions, BIT,
//             stack loads (PLP/RTI) and the set-overflow pin. Also produces
//             the delayed interrupt mask and the branch condition.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             alu_flag_n/v/c/z    - ALU flag results
//             upd_nz/upd_c/upd_v  - latch the corresponding ALU flags
//             flag_op[2:0]        - CLC/SEC/CLI/SEI/CLD/SED/CLV (000 = none)
//             bit_op              - BIT instruction update
//             load_p, data_in     - load flags from a stack byte
//             so_n                - set-overflow pin, active low
//             sync                - opcode-fetch strobe
//             push_brk            - B bit value for the pushed byte
//             branch_sel[2:0]     - branch condition selector
//             p_out[7:0]          - byte to push {N,V,1,B,D,I,Z,C}
//             carry_out           - stored C
//             decimal_out         - stored D
//             irq_mask            - I as seen by interrupt logic
//             branch_taken        - selected condition is true
//  Revision : 1.0 - initial release
// ============================================================================
module status_register (
   input  logic       clk,
   input  logic       rst,
   input  logic       alu_flag_n,
   input  logic       alu_flag_v,
   input  logic       alu_flag_c,
   input  logic       alu_flag_z,
   input  logic       upd_nz,
   input  logic       upd_c,
   input  logic       upd_v,
   input  logic [2:0] flag_op,
   input  logic       bit_op,
   input  logic       load_p,
   input  logic [7:0] data_in,
   input  logic       so_n,
   input  logic       sync,
   input  logic       push_brk,
   input  logic [2:0] branch_sel,
   output logic [7:0] p_out,
   output logic       carry_out,
   output logic       decimal_out,
   output logic       irq_mask,
   output logic       branch_taken
);

   // Flag instruction encodings
   localparam logic [2:0] c_FOP_NONE = 3'b000;
   localparam logic [2:0] c_FOP_CLC  = 3'b001;
   localparam logic [2:0] c_FOP_SEC  = 3'b010;
   localparam logic [2:0] c_FOP_CLI  = 3'b011;
   localparam logic [2:0] c_FOP_SEI  = 3'b100;
   localparam logic [2:0] c_FOP_CLD  = 3'b101;
   localparam logic [2:0] c_FOP_SED  = 3'b110;
   localparam logic [2:0] c_FOP_CLV  = 3'b111;

   // Branch condition encodings
   localparam logic [2:0] c_BR_BPL = 3'b000;
   localparam logic [2:0] c_BR_BMI = 3'b001;
   localparam logic [2:0] c_BR_BVC = 3'b010;
   localparam logic [2:0] c_BR_BVS = 3'b011;
   localparam logic [2:0] c_BR_BCC = 3'b100;
   localparam logic [2:0] c_BR_BCS = 3'b101;
   localparam logic [2:0] c_BR_BNE = 3'b110;
   localparam logic [2:0] c_BR_BEQ = 3'b111;

   // Stored flags and their next-state values
   logic r_n_q, w_n_d;
   logic r_v_q, w_v_d;
   logic r_d_q, w_d_d;
   logic r_i_q, w_i_d;
   logic r_z_q, w_z_d;
   logic r_c_q, w_c_d;

   // Interrupt mask copy and previous sample of the SO pin
   logic r_irq_q, w_irq_d;
   logic r_so_q;

   // Decoded flag instruction strobes
   logic w_fop_clc, w_fop_sec;
   logic w_fop_cli, w_fop_sei;
   logic w_fop_cld, w_fop_sed;
   logic w_fop_clv;

   // Falling edge on SO between the stored sample and the one being taken
   logic w_so_fall;

   // Stack bits 5:4 carry no state; they are dropped on load
   logic w_unused_din;
   assign w_unused_din = ^data_in[5:4];

   // -------------------------------------------------------------------------
   // Flag instruction decode
   // -------------------------------------------------------------------------
   always_comb begin
      w_fop_clc = (flag_op == c_FOP_CLC);
      w_fop_sec = (flag_op == c_FOP_SEC);
      w_fop_cli = (flag_op == c_FOP_CLI);
      w_fop_sei = (flag_op == c_FOP_SEI);
      w_fop_cld = (flag_op == c_FOP_CLD);
      w_fop_sed = (flag_op == c_FOP_SED);
      w_fop_clv = (flag_op == c_FOP_CLV);
   end

   // Fires exactly once per high-to-low transition, so a pin held low does
   // not keep re-asserting V and CLV can still clear it.
   assign w_so_fall = r_so_q & ~so_n;

   // -------------------------------------------------------------------------
   // Next-state logic. Each flag resolves its own sources in priority order:
   // stack load, then BIT, then explicit flag instruction, then ALU update.
   // A flag instruction only claims its own flag, so ALU updates to the other
   // flags still go through in the same cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      // N: load > BIT > ALU
      if (load_p)        w_n_d = data_in[7];
      else if (bit_op)   w_n_d = data_in[7];
      else if (upd_nz)   w_n_d = alu_flag_n;
      else               w_n_d = r_n_q;

      // V: SO falling edge beats every other source
      if (w_so_fall)     w_v_d = 1'b1;
      else if (load_p)   w_v_d = data_in[6];
      else if (bit_op)   w_v_d = data_in[6];
      else if (w_fop_clv) w_v_d = 1'b0;
      else if (upd_v)    w_v_d = alu_flag_v;
      else               w_v_d = r_v_q;

      // D: load > CLD/SED
      if (load_p)         w_d_d = data_in[3];
      else if (w_fop_cld) w_d_d = 1'b0;
      else if (w_fop_sed) w_d_d = 1'b1;
      else                w_d_d = r_d_q;

      // I: load > CLI/SEI
      if (load_p)         w_i_d = data_in[2];
      else if (w_fop_cli) w_i_d = 1'b0;
      else if (w_fop_sei) w_i_d = 1'b1;
      else                w_i_d = r_i_q;

      // Z: load > BIT (Z comes from the ALU AND result) > ALU
      if (load_p)        w_z_d = data_in[1];
      else if (bit_op)   w_z_d = alu_flag_z;
      else if (upd_nz)   w_z_d = alu_flag_z;
      else               w_z_d = r_z_q;

      // C: load > CLC/SEC > ALU
      if (load_p)         w_c_d = data_in[0];
      else if (w_fop_clc) w_c_d = 1'b0;
      else if (w_fop_sec) w_c_d = 1'b1;
      else if (upd_c)     w_c_d = alu_flag_c;
      else                w_c_d = r_c_q;

      // The mask samples the currently stored I at an instruction boundary.
      // An I write landing on the same edge is picked up at the next sync,
      // which gives CLI/SEI/PLP their one-instruction latency.
      if (sync) w_irq_d = r_i_q;
      else      w_irq_d = r_irq_q;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_n_q   <= 1'b0;
         r_v_q   <= 1'b0;
         r_d_q   <= 1'b0;
         r_i_q   <= 1'b1;
         r_z_q   <= 1'b0;
         r_c_q   <= 1'b0;
         r_irq_q <= 1'b1;
         r_so_q  <= 1'b1;
      end else begin
         r_n_q   <= w_n_d;
         r_v_q   <= w_v_d;
         r_d_q   <= w_d_d;
         r_i_q   <= w_i_d;
         r_z_q   <= w_z_d;
         r_c_q   <= w_c_d;
         r_irq_q <= w_irq_d;
         r_so_q  <= so_n;
      end
   end

   // -------------------------------------------------------------------------
   // Branch condition evaluation (no latency)
   // -------------------------------------------------------------------------
   always_comb begin
      branch_taken = 1'b0;
      case (branch_sel)
         c_BR_BPL: branch_taken = ~r_n_q;
         c_BR_BMI: branch_taken =  r_n_q;
         c_BR_BVC: branch_taken = ~r_v_q;
         c_BR_BVS: branch_taken =  r_v_q;
         c_BR_BCC: branch_taken = ~r_c_q;
         c_BR_BCS: branch_taken =  r_c_q;
         c_BR_BNE: branch_taken = ~r_z_q;
         c_BR_BEQ: branch_taken =  r_z_q;
         default:  branch_taken = 1'b0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign p_out       = {r_n_q, r_v_q, 1'b1, push_brk, r_d_q, r_i_q, r_z_q, r_c_q};
   assign carry_out   = r_c_q;
   assign decimal_out = r_d_q;
   assign irq_mask    = r_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_status_register.sv
`default_nettype none
// ============================================================================
//  Module   : tb_status_register
//  Purpose  : Self-checking bench for status_register. A flag-level model
//             applies each cycle's writes lowest-priority first so later
//             writes override earlier ones; a compare process checks every
//             output each cycle, and directed checks pin known values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_status_register;

   logic       clk = 1'b0;
   logic       rst;
   logic       alu_flag_n, alu_flag_v, alu_flag_c, alu_flag_z;
   logic       upd_nz, upd_c, upd_v;
   logic [2:0] flag_op;
   logic       bit_op, load_p;
   logic [7:0] data_in;
   logic       so_n, sync, push_brk;
   logic [2:0] branch_sel;
   logic [7:0] p_out;
   logic       carry_out, decimal_out, irq_mask, branch_taken;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   status_register dut (
      .clk          (clk),
      .rst          (rst),
      .alu_flag_n   (alu_flag_n),
      .alu_flag_v   (alu_flag_v),
      .alu_flag_c   (alu_flag_c),
      .alu_flag_z   (alu_flag_z),
      .upd_nz       (upd_nz),
      .upd_c        (upd_c),
      .upd_v        (upd_v),
      .flag_op      (flag_op),
      .bit_op       (bit_op),
      .load_p       (load_p),
      .data_in      (data_in),
      .so_n         (so_n),
      .sync         (sync),
      .push_brk     (push_brk),
      .branch_sel   (branch_sel),
      .p_out        (p_out),
      .carry_out    (carry_out),
      .decimal_out  (decimal_out),
      .irq_mask     (irq_mask),
      .branch_taken (branch_taken)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   logic m_n, m_v, m_d, m_i, m_z, m_c, m_mask, m_prev_so;
   logic m_valid = 1'b0;

   always @(posedge clk) begin
      logic old_i;
      if (rst) begin
         m_n = 0; m_v = 0; m_d = 0; m_z = 0; m_c = 0;
         m_i = 1; m_mask = 1; m_prev_so = 1; m_valid = 1;
      end else begin
         old_i = m_i;
         if (upd_nz) begin m_n = alu_flag_n; m_z = alu_flag_z; end
         if (upd_c) m_c = alu_flag_c;
         if (upd_v) m_v = alu_flag_v;
         case (flag_op)
            3'd1: m_c = 0;
            3'd2: m_c = 1;
            3'd3: m_i = 0;
            3'd4: m_i = 1;
            3'd5: m_d = 0;
            3'd6: m_d = 1;
            3'd7: m_v = 0;
            default: ;
         endcase
         if (bit_op) begin m_n = data_in[7]; m_v = data_in[6]; m_z = alu_flag_z; end
         if (load_p) begin
            m_n = data_in[7]; m_v = data_in[6]; m_d = data_in[3];
            m_i = data_in[2]; m_z = data_in[1]; m_c = data_in[0];
         end
         if (m_prev_so && !so_n) m_v = 1;
         if (sync) m_mask = old_i;
         m_prev_so = so_n;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      logic [3:0] fl;
      if (m_valid) begin
         fl = {m_z, m_c, m_v, m_n};
         chk("p_out", p_out, {m_n, m_v, 1'b1, push_brk, m_d, m_i, m_z, m_c});
         chk("carry_out", 8'(carry_out), 8'(m_c));
         chk("decimal_out", 8'(decimal_out), 8'(m_d));
         chk("irq_mask", 8'(irq_mask), 8'(m_mask));
         chk("branch_taken", 8'(branch_taken), 8'(fl[branch_sel[2:1]] == branch_sel[0]));
      end
   end

   // upd = {upd_nz, upd_c, upd_v}; alu = {n, v, c, z}
   task automatic apply(input logic [2:0] upd, input logic [2:0] fop, input logic bop,
                        input logic lp, input logic [7:0] din, input logic [3:0] alu,
                        input logic sy, input logic so, input logic r);
      {upd_nz, upd_c, upd_v} = upd;
      flag_op = fop;
      bit_op  = bop;
      load_p  = lp;
      data_in = din;
      {alu_flag_n, alu_flag_v, alu_flag_c, alu_flag_z} = alu;
      sync = sy;
      so_n = so;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   initial begin
      logic [7:0] exp_bt;
      push_brk = 0;
      branch_sel = 0;
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1);

      // Reset state
      chk("rst_p_out_b0", p_out, 8'h24);
      push_brk = 1; #1;
      chk("rst_p_out_b1", p_out, 8'h34);
      push_brk = 0; #1;
      chk("rst_carry", 8'(carry_out), 8'h00);
      chk("rst_decimal", 8'(decimal_out), 8'h00);
      chk("rst_irq", 8'(irq_mask), 8'h01);

      // ALU NZ + C update
      apply(3'b110, 0, 0, 0, 0, 4'b1010, 0, 1, 0);
      chk("alu_p_out", p_out, 8'hA5);
      chk("alu_carry", 8'(carry_out), 8'h01);
      branch_sel = 3'b101; #1;
      chk("alu_bcs", 8'(branch_taken), 8'h01);

      // Load beats CLC
      apply(0, 3'b001, 0, 1, 8'hFF, 0, 0, 1, 0);
      chk("load_p_out", p_out, 8'hEF);
      chk("load_carry", 8'(carry_out), 8'h01);

      // CLI coinciding with sync: mask lags by one instruction
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
      apply(0, 3'b011, 0, 0, 0, 0, 1, 1, 0);
      chk("cli_sync_irq", 8'(irq_mask), 8'h01);
      apply(0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("next_sync_irq", 8'(irq_mask), 8'h00);

      // SO held low five cycles, CLV on the third
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("so_v1", 8'(p_out[6]), 8'h01);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("so_v2", 8'(p_out[6]), 8'h01);
      apply(0, 3'b111, 0, 0, 0, 0, 0, 0, 0);
      chk("so_clv", 8'(p_out[6]), 8'h00);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("so_held", 8'(p_out[6]), 8'h00);

      // BIT
      apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
      apply(0, 0, 1, 0, 8'hC0, 4'b0001, 0, 1, 0);
      chk("bit_p_out", p_out, 8'hE6);
      branch_sel = 3'b111; #1;
      chk("bit_beq", 8'(branch_taken), 8'h01);

      // Reset beats load
      apply(0, 0, 0, 1, 8'hFF, 0, 0, 1, 1);
      chk("rst_load_p_out", p_out, 8'h24);
      chk("rst_load_irq", 8'(irq_mask), 8'h01);

      // Stack bits 5:4 are not stored
      apply(0, 0, 0, 1, 8'h30, 0, 0, 1, 0);
      chk("load30_p_out", p_out, 8'h20);

      // SED alongside full ALU update
      apply(3'b111, 3'b110, 0, 0, 0, 4'b1111, 0, 1, 0);
      chk("sed_alu", p_out, 8'hEB);
      // CLC beats upd_c
      apply(3'b010, 3'b001, 0, 0, 0, 4'b0010, 0, 1, 0);
      chk("clc_over_alu", p_out, 8'hEA);
      // CLV beats upd_v
      apply(3'b001, 3'b111, 0, 0, 0, 4'b0100, 0, 1, 0);
      chk("clv_over_alu", p_out, 8'hAA);
      // SO edge beats CLV
      apply(3'b001, 3'b111, 0, 0, 0, 4'b0000, 0, 0, 0);
      chk("so_over_clv", p_out, 8'hEA);
      // SEI with sync: mask takes old I (0)
      apply(0, 3'b100, 0, 0, 0, 0, 1, 1, 0);
      chk("sei_sync_irq", 8'(irq_mask), 8'h00);
      apply(0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("sei_next_irq", 8'(irq_mask), 8'h01);
      chk("sei_p_out", p_out, 8'hEE);

      // All branch conditions against N=1 V=1 Z=1 C=0
      exp_bt = 8'b1001_1010;
      for (int i = 0; i < 8; i++) begin
         branch_sel = 3'(i);
         push_brk = i[0];
         apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
         chk("branch_tbl", 8'(branch_taken), 8'(exp_bt[i]));
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
